riscv_instr_encoder: RTL

Field-level RISC-V RV32I instruction encoder and program streamer, the inverse of the core's instruction decoder. It accepts decoded fields (opcode, registers, funct3/funct7, signed immediate) over a valid/ready handshake and checks them for legality. It packs each legal request into a 32-bit instruction word and writes it to an instruction-memory write port at auto-incrementing word addresses. Used by the test/boot infrastructure to build programs in instruction RAM without an offline assembler.

---
 rtl/riscv_instr_encoder_pkg.sv | 64 ++++++
 rtl/riscv_instr_encoder_if.sv | 35 +++
 rtl/riscv_instr_pack.sv | 84 ++++++++
 rtl/riscv_instr_encoder.sv | 105 ++++++++++
 4 files changed

// File: rtl/riscv_instr_encoder_pkg.sv
// Shared RV32I opcode package for the instruction encoder.
// Provides the opcode and instruction-format enums, the immediate range limits and pure
// bit-packing functions for each base instruction format.
package riscv_instr_encoder_pkg;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpMiscMem = 7'b0001111,
    OpOpImm   = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpStore   = 7'b0100011,
    OpOp      = 7'b0110011,
    OpLui     = 7'b0110111,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpSystem  = 7'b1110011
  } riscv_opcode_t;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} riscv_instr_fmt_t;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BIMM_MIN  = -4096;
  localparam int BIMM_MAX  = 4094;
  localparam int JIMM_MIN  = -1048576;
  localparam int JIMM_MAX  = 1048574;

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // imm is the byte offset with bit 0 already dropped.
  function automatic logic [31:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] pack_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm_hi, rd, op};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/riscv_instr_encoder_if.sv
// Request and memory-write bus of the instruction encoder.
//   req_*  : decoded instruction fields with valid/ready handshake
//   mem_*  : instruction-memory write port (we/ready handshake)
// slave modport is the encoder's view, master is the driver/memory side.
interface riscv_instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_opcode;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [31:0]       req_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  req_valid, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output req_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output req_valid, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input  req_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/riscv_instr_pack.sv
// Combinational RV32I field packer and legality checker.
// Ports: opcode/rd/rs1/rs2/funct3/funct7/imm fields in; packed word_o and illegal_o out.
module riscv_instr_pack
  import riscv_instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);
  logic signed [31:0] imm_s;
  logic               in12, in_b, in_j, f7_alt, f7_zero;
  riscv_instr_fmt_t   fmt;
  logic [4:0]         rs2_sel;
  logic               legal;

  assign imm_s   = $signed(imm_i);
  assign in12    = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
  assign in_b    = (imm_s >= BIMM_MIN) && (imm_s <= BIMM_MAX) && !imm_i[0];
  assign in_j    = (imm_s >= JIMM_MIN) && (imm_s <= JIMM_MAX) && !imm_i[0];
  assign f7_zero = (funct7_i == 7'b0000000);
  assign f7_alt  = (funct7_i == 7'b0100000);

  always_comb begin
    fmt     = FmtI;
    rs2_sel = rs2_i;
    legal   = 1'b0;
    case (opcode_i)
      OpOp: begin
        fmt   = FmtR;
        legal = f7_zero || (f7_alt && (funct3_i == 3'b000 || funct3_i == 3'b101));
      end
      OpOpImm: begin
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          // Shifts reuse the R layout: shamt sits in the rs2 slot, funct7 above it.
          fmt     = FmtR;
          rs2_sel = imm_i[4:0];
          legal   = (imm_i[31:5] == '0) && (f7_zero || (f7_alt && funct3_i == 3'b101));
        end else begin
          legal = in12;
        end
      end
      OpLoad: legal = in12 && (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OpJalr, OpMiscMem: legal = in12 && (funct3_i == 3'b000);
      OpStore: begin
        fmt   = FmtS;
        legal = in12 && (funct3_i <= 3'b010);
      end
      OpBranch: begin
        fmt   = FmtB;
        legal = in_b && (funct3_i != 3'b010) && (funct3_i != 3'b011);
      end
      OpLui, OpAuipc: begin
        fmt   = FmtU;
        legal = (imm_i[11:0] == '0);
      end
      OpJal: begin
        fmt   = FmtJ;
        legal = in_j;
      end
      OpSystem: legal = (imm_i == 32'd0 || imm_i == 32'd1) && (rs1_i == '0) && (rd_i == '0) &&
                        (funct3_i == 3'b000);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (fmt)
      FmtR:    word_o = pack_r(funct7_i, rs2_sel, rs1_i, funct3_i, rd_i, opcode_i);
      FmtS:    word_o = pack_s(imm_i[11:0], rs2_i, rs1_i, funct3_i, opcode_i);
      FmtB:    word_o = pack_b(imm_i[12:1], rs2_i, rs1_i, funct3_i, opcode_i);
      FmtU:    word_o = pack_u(imm_i[31:12], rd_i, opcode_i);
      FmtJ:    word_o = pack_j(imm_i[20:1], rd_i, opcode_i);
      default: word_o = pack_i(imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i);
    endcase
  end

  assign illegal_o = !legal;
endmodule

// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder / program streamer.
// Accepts decoded fields on bus.req_*, writes each legal encoded word to bus.mem_* at
// auto-incrementing word addresses; rejected requests pulse err_o and bump err_count_o.
// Ports: clk, rst_n (async active-low), start_i/base_addr_i open a session, stop_i closes it
// after draining (done_o pulse), busy_o high outside idle.
module riscv_instr_encoder
  import riscv_instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic                  stop_i,
  riscv_instr_encoder_if.slave  bus,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic                  done_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q, mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  mem_we_q, err_q, done_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [31:0]           word;
  logic                  illegal;
  logic                  out_free, req_fire;

  riscv_instr_pack u_pack (
    .opcode_i  (bus.req_opcode),
    .rd_i      (bus.req_rd),
    .rs1_i     (bus.req_rs1),
    .rs2_i     (bus.req_rs2),
    .funct3_i  (bus.req_funct3),
    .funct7_i  (bus.req_funct7),
    .imm_i     (bus.req_imm),
    .word_o    (word),
    .illegal_o (illegal)
  );

  // Output register is free if empty or being consumed this cycle.
  assign out_free      = !mem_we_q || bus.mem_ready;
  assign bus.req_ready = (state_q == StRun) && out_free;
  assign req_fire      = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      if (mem_we_q && bus.mem_ready) mem_we_q <= 1'b0;
      if (req_fire) begin
        if (illegal) begin
          err_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end else begin
          // addr_q tracks the next address to hand out, so it advances on acceptance;
          // every accepted legal request is written exactly once.
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= word;
          addr_q      <= addr_q + ADDR_W'(4);
        end
      end
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StRun;
            addr_q    <= base_addr_i & ~ADDR_W'(3);
            err_cnt_q <= '0;
          end
        end
        StRun: if (stop_i) state_q <= StDrain;
        StDrain: begin
          if (out_free) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign err_o         = err_q;
  assign err_count_o   = err_cnt_q;
  assign done_o        = done_q;
  assign busy_o        = (state_q != StIdle);
endmodule
